// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among ALU, load and mult/div writeback,
// and keeps a per-register scoreboard of outstanding multi-cycle writes.
module regfile_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [2:0]  req_valid,
    input  logic [4:0]  req_reg0,
    input  logic [4:0]  req_reg1,
    input  logic [4:0]  req_reg2,
    input  logic [31:0] req_data0,
    input  logic [31:0] req_data1,
    input  logic [31:0] req_data2,
    output logic [2:0]  req_ready,

    input  logic        issue_valid,
    input  logic [4:0]  issue_reg,
    output logic        issue_ready,

    input  logic [4:0]  rd1,
    input  logic [4:0]  rd2,
    output logic        rd1_pending,
    output logic        rd2_pending,

    output logic        write,
    output logic [4:0]  writeRegister,
    output logic [31:0] rr
);

    logic [4:0]  port_reg  [3];
    logic [31:0] port_data [3];

    assign port_reg[0]  = req_reg0;
    assign port_reg[1]  = req_reg1;
    assign port_reg[2]  = req_reg2;
    assign port_data[0] = req_data0;
    assign port_data[1] = req_data1;
    assign port_data[2] = req_data2;

    // rr_ptr_q: 0 prefers port 1, 1 prefers port 2
    logic        rr_ptr_q, rr_ptr_d;
    logic [2:0]  starve_cnt_q, starve_cnt_d;
    logic        write_q, write_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] pend_set, pend_clr;

    logic        block0;
    logic [2:0]  grant;
    logic        xfer;
    logic        xfer12;
    logic [4:0]  xfer_reg;
    logic [31:0] xfer_data;
    logic        issue_fire;

    assign block0 = (32'(starve_cnt_q) >= STARVE_LIMIT);

    always_comb begin
        grant = 3'b000;
        if (req_valid[0] && !block0) begin
            grant[0] = 1'b1;
        end else if (!rr_ptr_q) begin
            if (req_valid[1])      grant[1] = 1'b1;
            else if (req_valid[2]) grant[2] = 1'b1;
        end else begin
            if (req_valid[2])      grant[2] = 1'b1;
            else if (req_valid[1]) grant[1] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;
    assign xfer12    = grant[1] | grant[2];

    // grant is one-hot or zero, so an AND-OR mux selects the winner
    always_comb begin
        xfer_reg  = 5'd0;
        xfer_data = 32'd0;
        for (int i = 0; i < 3; i++) begin
            xfer_reg  = xfer_reg  | ({5{grant[i]}}  & port_reg[i]);
            xfer_data = xfer_data | ({32{grant[i]}} & port_data[i]);
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant[1])      rr_ptr_d = 1'b1;
        else if (grant[2]) rr_ptr_d = 1'b0;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (xfer12 || !(req_valid[1] || req_valid[2])) begin
            starve_cnt_d = 3'd0;
        end else if (starve_cnt_q != 3'd7) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
        end
    end

    // A write to $zero is still a transfer, it just never enables the file
    assign write_d = xfer && (xfer_reg != 5'd0);
    assign wreg_d  = xfer ? xfer_reg  : wreg_q;
    assign wdata_d = xfer ? xfer_data : wdata_q;

    assign issue_ready = !pending_q[issue_reg];
    assign issue_fire  = issue_valid && issue_ready;

    assign pend_set[0]  = 1'b0;
    assign pend_clr[0]  = 1'b0;
    assign pending_d[0] = 1'b0;

    // Set wins over a same-cycle clear of the same register
    for (genvar gi = 1; gi < 32; gi++) begin : g_pend
        assign pend_clr[gi]  = xfer12 && (xfer_reg == 5'(gi));
        assign pend_set[gi]  = issue_fire && (issue_reg == 5'(gi));
        assign pending_d[gi] = pend_set[gi] | (pending_q[gi] & ~pend_clr[gi]);
    end

    // Data accepted this cycle is not in the file until after the next edge
    assign rd1_pending = pending_q[rd1] | (xfer12 && (xfer_reg == rd1) && (rd1 != 5'd0));
    assign rd2_pending = pending_q[rd2] | (xfer12 && (xfer_reg == rd2) && (rd2 != 5'd0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q     <= 1'b0;
            starve_cnt_q <= 3'd0;
            write_q      <= 1'b0;
            wreg_q       <= 5'd0;
            wdata_q      <= 32'd0;
            pending_q    <= 32'd0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            write_q      <= write_d;
            wreg_q       <= wreg_d;
            wdata_q      <= wdata_d;
            pending_q    <= pending_d;
        end
    end

    assign write         = write_q;
    assign writeRegister = wreg_q;
    assign rr            = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected write beats are queued
// as each cycle's stimulus is driven and popped when the write port updates.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset_n;
    logic [2:0]  req_valid;
    logic [4:0]  req_reg0, req_reg1, req_reg2;
    logic [31:0] req_data0, req_data1, req_data2;
    logic [2:0]  req_ready;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic        issue_ready;
    logic [4:0]  rd1, rd2;
    logic        rd1_pending, rd2_pending;
    logic        write;
    logic [4:0]  writeRegister;
    logic [31:0] rr;

    regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_reg0      (req_reg0),
        .req_reg1      (req_reg1),
        .req_reg2      (req_reg2),
        .req_data0     (req_data0),
        .req_data1     (req_data1),
        .req_data2     (req_data2),
        .req_ready     (req_ready),
        .issue_valid   (issue_valid),
        .issue_reg     (issue_reg),
        .issue_ready   (issue_ready),
        .rd1           (rd1),
        .rd2           (rd2),
        .rd1_pending   (rd1_pending),
        .rd2_pending   (rd2_pending),
        .write         (write),
        .writeRegister (writeRegister),
        .rr            (rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [4:0]  r;
        logic [31:0] d;
    } beat_t;

    beat_t       sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [4:0]  last_reg  = 5'd0;
    logic [31:0] last_data = 32'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock of stimulus: combinational outputs checked mid-cycle,
    // the resulting write beat queued and compared after the edge.
    task automatic step(input string tag, input logic [2:0] v,
                        input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                        input logic iv, input logic [4:0] ir,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic [2:0] eg, input logic eir, input logic ep1, input logic ep2);
        beat_t exp_b, got_b;
        @(negedge clk);
        req_valid = v;
        req_reg0 = r0; req_reg1 = r1; req_reg2 = r2;
        req_data0 = d0; req_data1 = d1; req_data2 = d2;
        issue_valid = iv; issue_reg = ir;
        rd1 = a1; rd2 = a2;
        #1;
        check_val({tag, ".req_ready"},   32'(req_ready),   32'(eg));
        check_val({tag, ".issue_ready"}, 32'(issue_ready), 32'(eir));
        check_val({tag, ".rd1_pending"}, 32'(rd1_pending), 32'(ep1));
        check_val({tag, ".rd2_pending"}, 32'(rd2_pending), 32'(ep2));
        case (eg)
            3'b001:  begin last_reg = r0; last_data = d0; end
            3'b010:  begin last_reg = r1; last_data = d1; end
            3'b100:  begin last_reg = r2; last_data = d2; end
            default: ;
        endcase
        exp_b.w = (eg != 3'b000) && (last_reg != 5'd0);
        exp_b.r = last_reg;
        exp_b.d = last_data;
        sb_q.push_back(exp_b);
        @(posedge clk);
        #1;
        got_b = sb_q.pop_front();
        check_val({tag, ".write"},         32'(write),         32'(got_b.w));
        check_val({tag, ".writeRegister"}, 32'(writeRegister), 32'(got_b.r));
        check_val({tag, ".rr"},            rr,                 got_b.d);
        $display("%-10s grant=%b issue_ready=%b p1=%b p2=%b write=%b reg=%0d data=%h",
                 tag, req_ready, issue_ready, rd1_pending, rd2_pending, write, writeRegister, rr);
    endtask

    task automatic idle(input string tag);
        step(tag, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
             1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        req_valid = 3'b000;
        req_reg0 = 5'd0; req_reg1 = 5'd0; req_reg2 = 5'd0;
        req_data0 = 32'd0; req_data1 = 32'd0; req_data2 = 32'd0;
        issue_valid = 1'b0; issue_reg = 5'd0;
        rd1 = 5'd0; rd2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst.write",         32'(write),         32'd0);
        check_val("rst.writeRegister", 32'(writeRegister), 32'd0);
        check_val("rst.rr",            rr,                 32'd0);
        check_val("rst.issue_ready",   32'(issue_ready),   32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // priority then round-robin alternation between ports 1 and 2
        for (int i = 0; i < 3; i++)
            step("prio", 3'b111, 5'd3, 5'd4, 5'd5, 32'hA, 32'hB, 32'hC,
                 1'b0, 5'd0, 5'd4, 5'd5, 3'b001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                step("rr_p1", 3'b110, 5'd3, 5'd4, 5'd5, 32'hA, 32'hB, 32'hC,
                     1'b0, 5'd0, 5'd4, 5'd5, 3'b010, 1'b1, 1'b1, 1'b0);
            else
                step("rr_p2", 3'b110, 5'd3, 5'd4, 5'd5, 32'hA, 32'hB, 32'hC,
                     1'b0, 5'd0, 5'd4, 5'd5, 3'b100, 1'b1, 1'b0, 1'b1);
        end
        idle("idle");

        // starvation: port 1 forces its way in on the fifth cycle
        for (int i = 0; i < 4; i++)
            step("starve", 3'b011, 5'd6, 5'd7, 5'd0, 32'h60, 32'h70, 32'd0,
                 1'b0, 5'd0, 5'd7, 5'd0, 3'b001, 1'b1, 1'b0, 1'b0);
        step("starve_p1", 3'b011, 5'd6, 5'd7, 5'd0, 32'h60, 32'h70, 32'd0,
             1'b0, 5'd0, 5'd7, 5'd0, 3'b010, 1'b1, 1'b1, 1'b0);
        step("resume_p0", 3'b011, 5'd6, 5'd7, 5'd0, 32'h60, 32'h70, 32'd0,
             1'b0, 5'd0, 5'd7, 5'd0, 3'b001, 1'b1, 1'b0, 1'b0);
        idle("idle");

        // $zero: accepted but never enables the register file
        step("zero", 3'b100, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'hDEADBEEF,
             1'b0, 5'd0, 5'd8, 5'd9, 3'b100, 1'b1, 1'b0, 1'b0);
        idle("idle");

        // scoreboard set, WAW refusal, clear by port 2, reissue
        step("iss8", 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
             1'b1, 5'd8, 5'd8, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0);
        step("waw8", 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
             1'b1, 5'd8, 5'd8, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0);
        step("clr8", 3'b100, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'h88,
             1'b0, 5'd8, 5'd8, 5'd0, 3'b100, 1'b0, 1'b1, 1'b0);
        step("reiss8", 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
             1'b1, 5'd8, 5'd8, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0);

        // set/clear collision on register 9
        step("iss9", 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
             1'b1, 5'd9, 5'd8, 5'd9, 3'b000, 1'b1, 1'b1, 1'b0);
        step("coll9", 3'b010, 5'd0, 5'd9, 5'd0, 32'd0, 32'h99, 32'd0,
             1'b1, 5'd9, 5'd8, 5'd9, 3'b010, 1'b0, 1'b1, 1'b1);
        step("retry9", 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
             1'b1, 5'd9, 5'd8, 5'd9, 3'b000, 1'b1, 1'b1, 1'b0);

        // async reset mid-stream with 8 and 9 pending and a write in flight
        step("pre_rst", 3'b001, 5'd10, 5'd0, 5'd0, 32'h1010, 32'd0, 32'd0,
             1'b0, 5'd0, 5'd8, 5'd9, 3'b001, 1'b1, 1'b1, 1'b1);
        #2;
        reset_n = 1'b0;
        req_valid = 3'b000;
        #1;
        check_val("arst.write",         32'(write),         32'd0);
        check_val("arst.writeRegister", 32'(writeRegister), 32'd0);
        check_val("arst.rr",            rr,                 32'd0);
        check_val("arst.rd1_pending",   32'(rd1_pending),   32'd0);
        check_val("arst.rd2_pending",   32'(rd2_pending),   32'd0);
        last_reg  = 5'd0;
        last_data = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        step("post_rst", 3'b110, 5'd0, 5'd11, 5'd12, 32'd0, 32'h11, 32'h12,
             1'b0, 5'd0, 5'd8, 5'd9, 3'b010, 1'b1, 1'b0, 1'b0);
        idle("idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port among three writeback requesters and tracks registers with outstanding multi-cycle writes. Sits between the writeback sources (ALU, load unit, mult/div unit) and the `registers` write inputs (`write`, `writeRegister`, `rr`). It also gives the decode stage per-operand pending flags for hazard stalling.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive cycles a waiting port 1/2 request may be denied before port 0 is blocked for one cycle.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid[2:0]`  in  3  per-port write request. Port 0 = ALU, 1 = load, 2 = mult/div.
- `req_reg0`, `req_reg1`, `req_reg2`  in  5 each  destination register per port.
- `req_data0`, `req_data1`, `req_data2`  in  32 each  write data per port.
- `req_ready[2:0]`  out  3  grant. A transfer occurs on a port when `req_valid` and `req_ready` are both 1 at a rising edge.
- `issue_valid`  in  1  decode issues a multi-cycle op that will write `issue_reg`.
- `issue_reg`  in  5  destination of the issued op.
- `issue_ready`  out  1  issue accepted. Low when `issue_reg` is already pending.
- `rd1`, `rd2`  in  5 each  decode source operands.
- `rd1_pending`, `rd2_pending`  out  1 each  operand has an outstanding write.
- `write`  out  1  register file write enable (registered).
- `writeRegister`  out  5  register file write address (registered).
- `rr`  out  32  register file write data (registered).

## Operation
- **Grant (combinational, at most one bit of `req_ready` high):**
  - Port 0 has fixed priority: `req_ready[0] = req_valid[0] & !block0`.
  - If port 0 is not granted, ports 1 and 2 are arbitrated round-robin using pointer `rr_ptr` (1 or 2). The port named by `rr_ptr` is preferred; the other port is granted if the preferred one is not valid.
  - `req_ready` is high only when the matching `req_valid` is high.
- **Round-robin pointer:** after a transfer on port 1, `rr_ptr` becomes 2. After a transfer on port 2, it becomes 1. Transfers on port 0 leave it unchanged.
- **Starvation counter `starve_cnt`** (3 bits, saturating):
  - Increments each cycle in which `req_valid[1]|req_valid[2]` is high and no port 1/2 transfer occurs.
  - Clears to 0 on any port 1/2 transfer, or when neither port 1 nor port 2 is valid.
  - `block0 = (starve_cnt >= STARVE_LIMIT)`.
- **Write-port register:** on a transfer,
  - `writeRegister` and `rr` load the granted port's register and data.
  - `write` is set to 1 if that register is nonzero. A write to $zero is accepted but drives `write = 0`.
  - With no transfer, `write` is 0 and `writeRegister`/`rr` hold their values.
- **Pending scoreboard `pending[31:0]`:**
  - Set: on the edge where `issue_valid & issue_ready` and `issue_reg != 0`, `pending[issue_reg]` is set.
  - Clear: `pending[r]` is cleared on the edge where a transfer to register `r` occurs on port 1 or 2. Port 0 never clears pending bits.
  - Same-cycle set and clear of the same register: set wins.
  - `pending[0]` is always 0.
- **Issue acceptance:** `issue_ready = !pending[issue_reg]`. A second outstanding write to the same register (WAW) is refused. This is combinational and does not see a same-cycle clear.
- **Hazard flags (combinational):**
  - `rd1_pending = pending[rd1]`, `rd2_pending = pending[rd2]`.
  - A flag is also high when a port 1/2 transfer to that register is accepted in the current cycle, because the data is not yet in the register file.

## Timing
- **Reset (async assert, sync release):** `write = 0`, `writeRegister = 0`, `rr = 0`, `pending = 0`, `rr_ptr = 1`, `starve_cnt = 0`.
- **Write latency:** a transfer at edge N drives `write`/`writeRegister`/`rr` during cycle N..N+1. The register file holds the value from edge N+1 onward. One write occurs per cycle at most.
- **Back-to-back:** a different port can be granted every cycle, so throughput is 1 write per clock.
- **Scoreboard:** `issue_ready` responds in the same cycle. A pending bit set at edge N is visible on `rd*_pending` from cycle N onward. A bit cleared at edge N is low from cycle N, matching the write becoming visible at N+1, one cycle later. Decode must honour the same-cycle acceptance term.
- **Reset mid-operation:** in-flight writes are dropped, `write` is forced to 0 immediately, and all pending bits are cleared.

## Test plan
- **Priority and round-robin:** all ports valid with regs 3/4/5, data 0xA/0xB/0xC for 3 cycles, then port 0 drops → grants 0,0,0 and then 1,2,1 alternating. `writeRegister`/`rr` follow one cycle behind each grant.
- **Starvation:** port 0 and port 1 valid continuously, `STARVE_LIMIT = 4` → port 0 granted 4 cycles, port 1 granted on cycle 5, port 0 resumes on cycle 6.
- **$zero:** port 2 writes reg 0, data 0xDEADBEEF → `req_ready[2] = 1`, next cycle `write = 0`, no pending change.
- **Scoreboard:** issue reg 8 → `issue_ready = 1`. Next cycle re-issue reg 8 → `issue_ready = 0`, `rd1 = 8` gives `rd1_pending = 1`. Port 2 writes reg 8 → pending clears. Re-issue of reg 8 is accepted the following cycle.
- **Set/clear collision:** port 1 writes reg 9 (pending) in the same cycle a new issue of reg 9 is presented → issue refused (`issue_ready = 0`), pending clears. The issue succeeds on the retry next cycle.
- **Async reset:** assert `reset_n = 0` mid-stream with pending regs 8 and 9 and `write = 1` → all outputs 0 immediately. After release, the first grant goes to port 1 among ports 1 and 2.
